odo_loop_scheduler: RTL and testbench
=====================================

# odo_loop_scheduler

Issue scheduler and result collector for the Odo encryption loop. It accepts 640-bit work items with tags from an upstream valid/ready source and decides which ring cycles may launch a new item into the non-stallable loop. It pairs each loop result with its tag and buffers results so downstream backpressure never causes a result to be lost. It sits between the hash-input stage and the Odo loop, and owns every loop control signal.

## Interface
- `RING_LEN`, 19: loop recirculation period in cycles; the number of issue slots.
- `LAPS`, 10: ring revolutions a slot stays occupied after issue; ceil(`LATENCY`/`RING_LEN`).
- `LATENCY`, 178: cycles from `loop_read` high to `loop_write` high.
- `TAG_W`, 8: tag width.
- `OUT_DEPTH`, 32: result FIFO depth; must be ≥ `RING_LEN`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: work item offered.
- `in_ready`, out, 1: work item accepted this cycle when high together with `in_valid`.
- `in_data`, in, 640: block to encrypt.
- `in_tag`, in, `TAG_W`: requester tag.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, 640: encrypted block.
- `out_tag`, out, `TAG_W`: tag of the result.
- `loop_read`, out, 1: drives the loop's `read`.
- `loop_in`, out, 640: drives the loop's `in`.
- `loop_write`, in, 1: loop result strobe.
- `loop_out`, in, 640: loop result.
- `busy`, out, 1: draining, or any item in flight or buffered.
- `protocol_err`, out, 1: sticky; set when `loop_write` arrives with no outstanding tag.

## Operation
- FSM states:
  - DRAIN: entered on reset. A counter loads `LATENCY`+1 and decrements every cycle. `in_ready`=0. `loop_write` is ignored, because the loop has no reset and may still hold pre-reset traffic. Go to RUN when the counter reaches 0.
  - RUN: normal operation; no exit except reset.
- Slot ring:
  - `head` counter, 0..`RING_LEN`-1, increments every cycle and wraps `RING_LEN`-1→0.
  - Per-slot lap counter, 0..`LAPS`. When `head` reaches a slot with a nonzero count, the count decrements.
  - A slot is free when its count is 0, including the cycle it reaches 0.
- Issue:
  - `in_ready` = RUN & slot[`head`] free & credit available.
  - Credit available means (tags outstanding + FIFO occupancy) < `OUT_DEPTH`.
  - On accept, slot[`head`] count is set to `LAPS` and `in_tag` is pushed to the tag FIFO (depth `RING_LEN`).
  - `loop_read` = `in_valid` & `in_ready` (combinational). `loop_in` = `in_data` (combinational pass-through).
- Collect:
  - In RUN, on `loop_write`, pop the tag FIFO and write {`loop_out`, tag} into the result FIFO.
  - If the tag FIFO is empty, set `protocol_err` and drop the result.
- Output:
  - `out_valid` = result FIFO not empty; `out_data`/`out_tag` show the FIFO head.
  - Pop on `out_valid` & `out_ready`.
- Simultaneous collect and pop in the same cycle: occupancy is unchanged. Credit is computed from registered counts, so a same-cycle release does not enable issue until the next cycle.
- Credit guarantees the result FIFO never overflows; the loop is never stalled.

## Timing
- Reset values: `in_ready`=0, `loop_read`=0, `out_valid`=0, `busy`=1 (DRAIN), `protocol_err`=0, all counters and FIFOs cleared, `head`=0.
- First possible accept: cycle `LATENCY`+1 after `rst_n` deasserts.
- Issue rate: at most 1 item/cycle, and at most `RING_LEN` items in flight.
- Per-slot reuse: a slot issued at cycle t can next issue at cycle t + `LAPS`×`RING_LEN` (190 with defaults).
- Result `out_valid` rises 1 cycle after `loop_write`, i.e. `LATENCY`+1 cycles after accept.
- Order: results leave in issue order.
- `rst_n` asserted mid-operation: all in-flight items and buffered results are discarded, `out_valid` drops immediately (asynchronously), and the block re-enters DRAIN.

## Configuration
- `ODO_SCHED_STATS_EN`: when defined, adds three 32-bit wrapping outputs, reset to 0:
  - `stat_issued`: accepts.
  - `stat_done`: output pops.
  - `stat_stall`: cycles with `in_valid` & !`in_ready` in RUN.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with `in_valid`=1: `in_ready` stays 0 for 179 cycles. Inject a spurious `loop_write` at cycle 50: no `out_valid`, and `protocol_err`=0.
- Single item, tag 0x5A, accepted at cycle T: `out_valid`=1 at T+179 with `out_tag`=0x5A and `out_data` equal to the loop model output.
- Continuous `in_valid` with `out_ready`=1: 19 accepts in 19 consecutive cycles, then `in_ready`=0 until slot 0 frees 190 cycles after its issue; results come out in order with tags 0..18.
- `out_ready`=0 throughout: accepts stop once outstanding plus buffered reaches 32. Raise `out_ready`: 32 results drain one per cycle, then issue resumes.
- Extra `loop_write` with no outstanding tag in RUN: `protocol_err` rises and stays 1 until reset; FIFO occupancy is unchanged.
- Assert `rst_n` with 10 items in flight: `out_valid` drops immediately, `busy`=1, 179-cycle DRAIN follows, and no stale result ever appears at the output.

Source files
------------

// File: rtl/odo_loop_scheduler.sv
// odo_loop_scheduler: issue scheduler and tagged result collector for the non-stallable Odo loop.
// Defining ODO_SCHED_STATS_EN adds the stat_issued/stat_done/stat_stall counters.
module odo_loop_scheduler #(
   parameter int RING_LEN  = 19,
   parameter int LAPS      = 10,
   parameter int LATENCY   = 178,
   parameter int TAG_W     = 8,
   parameter int OUT_DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [639:0]     in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [639:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             loop_read,
   output logic [639:0]     loop_in,
   input  logic             loop_write,
   input  logic [639:0]     loop_out,
   output logic             busy,
`ifdef ODO_SCHED_STATS_EN
   output logic             protocol_err,
   output logic [31:0]      stat_issued,
   output logic [31:0]      stat_done,
   output logic [31:0]      stat_stall
`else
   output logic             protocol_err
`endif
);
   localparam int HW  = $clog2(RING_LEN);
   localparam int LW  = $clog2(LAPS + 1);
   localparam int TCW = $clog2(RING_LEN + 1);
   localparam int RPW = $clog2(OUT_DEPTH);
   localparam int RCW = $clog2(OUT_DEPTH + 1);
   localparam int CW  = RCW + 1;
   localparam int DW  = $clog2(LATENCY + 2);
   localparam int EW  = 640 + TAG_W;

   typedef enum logic {S_DRAIN, S_RUN} state_t;

   state_t           r_state, w_state_nxt;
   logic [DW-1:0]    r_drain, w_drain_nxt;
   logic [HW-1:0]    r_head;
   logic [LW-1:0]    r_lap [RING_LEN];
   logic [TAG_W-1:0] r_tag_mem [RING_LEN];
   logic [HW-1:0]    r_twp, r_trp;
   logic [TCW-1:0]   r_tcnt;
   logic [EW-1:0]    r_res_mem [OUT_DEPTH];
   logic [RPW-1:0]   r_rwp, r_rrp;
   logic [RCW-1:0]   r_rcnt;
   logic             r_err;
   logic             w_run, w_free, w_credit, w_acc, w_collect, w_tpop, w_rpop;

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      if (r_state == S_DRAIN) begin
         w_drain_nxt = r_drain - 1'b1;
         w_state_nxt = (r_drain == DW'(1)) ? S_RUN : S_DRAIN;
      end
   end

   // A slot whose lap count expires this very cycle may be reissued immediately.
   assign w_run     = (r_state == S_RUN);
   assign w_free    = (r_lap[r_head] <= LW'(1));
   assign w_credit  = (CW'(r_tcnt) + CW'(r_rcnt)) < CW'(OUT_DEPTH);
   assign in_ready  = w_run & w_free & w_credit;
   assign w_acc     = in_valid & in_ready;
   assign w_collect = w_run & loop_write;
   assign w_tpop    = w_collect & (r_tcnt != '0);
   assign w_rpop    = out_valid & out_ready;

   assign loop_read          = w_acc;
   assign loop_in            = in_data;
   assign out_valid          = (r_rcnt != '0);
   assign {out_data, out_tag} = r_res_mem[r_rrp];
   assign busy               = ~w_run | (r_tcnt != '0) | (r_rcnt != '0);
   assign protocol_err       = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_DRAIN;
         r_drain <= DW'(LATENCY + 1);
         r_head  <= '0;
         for (int i = 0; i < RING_LEN; i++) r_lap[i] <= '0;
         r_twp   <= '0;
         r_trp   <= '0;
         r_tcnt  <= '0;
         r_rwp   <= '0;
         r_rrp   <= '0;
         r_rcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= w_drain_nxt;
         r_head  <= (r_head == HW'(RING_LEN - 1)) ? '0 : r_head + 1'b1;
         for (int i = 0; i < RING_LEN; i++)
            if (HW'(i) == r_head)
               r_lap[i] <= w_acc ? LW'(LAPS) : r_lap[i] - LW'(r_lap[i] != '0);
         if (w_acc) r_twp <= (r_twp == HW'(RING_LEN - 1)) ? '0 : r_twp + 1'b1;
         if (w_tpop) r_trp <= (r_trp == HW'(RING_LEN - 1)) ? '0 : r_trp + 1'b1;
         r_tcnt  <= r_tcnt + TCW'(w_acc) - TCW'(w_tpop);
         if (w_tpop) r_rwp <= (r_rwp == RPW'(OUT_DEPTH - 1)) ? '0 : r_rwp + 1'b1;
         if (w_rpop) r_rrp <= (r_rrp == RPW'(OUT_DEPTH - 1)) ? '0 : r_rrp + 1'b1;
         r_rcnt  <= r_rcnt + RCW'(w_tpop) - RCW'(w_rpop);
         r_err   <= r_err | (w_collect & (r_tcnt == '0));
      end
   end

   // Storage needs no reset: occupancy counts alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_acc) r_tag_mem[r_twp] <= in_tag;
      if (w_tpop) r_res_mem[r_rwp] <= {loop_out, r_tag_mem[r_trp]};
   end

`ifdef ODO_SCHED_STATS_EN
   logic [31:0] r_stat_issued, r_stat_done, r_stat_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_issued <= '0;
         r_stat_done   <= '0;
         r_stat_stall  <= '0;
      end else begin
         r_stat_issued <= r_stat_issued + 32'(w_acc);
         r_stat_done   <= r_stat_done + 32'(w_rpop);
         r_stat_stall  <= r_stat_stall + 32'(w_run & in_valid & ~in_ready);
      end
   end

   assign stat_issued = r_stat_issued;
   assign stat_done   = r_stat_done;
   assign stat_stall  = r_stat_stall;
`endif
endmodule

// File: tb/tb_odo_loop_scheduler.sv
// tb_odo_loop_scheduler: random stimulus against a slot/credit reference model,
// with a loop delay model and a scoreboard monitor on the result port.
module tb_odo_loop_scheduler;
   localparam int RING = 19;
   localparam int LAPS = 10;
   localparam int LAT  = 178;
   localparam int ODEP = 32;

   typedef struct {int due; logic [639:0] d;} lw_t;
   typedef struct {logic [639:0] d; logic [7:0] t;} res_t;

   logic         clk, rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic         loop_read, loop_write, busy, protocol_err;
   logic [639:0] in_data, out_data, loop_in, loop_out;
   logic [7:0]   in_tag, out_tag;

   lw_t  lq[$];
   res_t sb[$];
   int   checks, errors, tick, rel, n_acc, n_pop, t0, p0;
   int   last[RING];
   bit   rel_pend, seen;
   logic [7:0] next_tag;

   odo_loop_scheduler dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .loop_read(loop_read), .loop_in(loop_in),
      .loop_write(loop_write), .loop_out(loop_out), .busy(busy), .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [639:0] enc(input logic [639:0] x);
      return {x[638:0], x[639]} ^ {20{32'h9E37_79B9}};
   endfunction

   task automatic check(input logic [63:0] act, input logic [63:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, then judge against the model.
   task automatic step(input bit iv, input bit ordy, input bit spur);
      logic [639:0] d;
      bit exp_rdy;
      @(negedge clk);
      tick++;
      if (rel_pend) begin
         rst_n = 1'b1;
         rel = 0;
         rel_pend = 1'b0;
      end else rel++;
      for (int i = 0; i < 20; i++) d[i*32 +: 32] = $urandom;
      in_valid = iv;
      in_data = d;
      in_tag = next_tag;
      out_ready = ordy;
      loop_write = 1'b0;
      if (lq.size() != 0 && lq[0].due == tick) begin
         loop_write = 1'b1;
         loop_out = lq[0].d;
         lq.delete(0);
      end else if (spur) begin
         loop_write = 1'b1;
         loop_out = d;
      end
      #1;
      if (loop_read === 1'b1) lq.push_back('{tick + LAT, enc(loop_in)});
      if (rst_n) begin
         exp_rdy = rel >= LAT + 1 && rel - last[rel % RING] >= LAPS * RING && n_acc - n_pop < ODEP;
         check(in_ready, exp_rdy, "in_ready");
         check(loop_read, iv & exp_rdy, "loop_read");
         if (iv && exp_rdy) begin
            checks++;
            if (loop_in !== d) begin
               errors++;
               $display("FAIL loop_in: got low %h expected low %h", loop_in[63:0], d[63:0]);
            end
            sb.push_back('{enc(d), next_tag});
            last[rel % RING] = rel;
            n_acc++;
            next_tag++;
         end
      end
   endtask

   task automatic reset_tail();
      sb.delete();
      n_acc = 0;
      n_pop = 0;
      next_tag = 8'h00;
      foreach (last[i]) last[i] = -1000;
      rel = -1000;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      rel_pend = 1'b1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check(out_valid, 0, "rst_out_valid");
      check(busy, 1, "rst_busy");
      check(in_ready, 0, "rst_in_ready");
      check(protocol_err, 0, "rst_protocol_err");
      reset_tail();
   endtask

   always begin
      res_t e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL stale_out: out_valid=1 tag %0h, required no result pending", out_tag);
         end else if (out_ready) begin
            e = sb.pop_front();
            n_pop++;
            if (out_tag !== e.t) begin
               errors++;
               $display("FAIL out_tag: got %0h expected %0h", out_tag, e.t);
            end
            checks++;
            if (out_data !== e.d) begin
               errors++;
               $display("FAIL out_data tag %0h: got %h expected %h", e.t, out_data, e.d);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      loop_write = 1'b0;
      in_data = '0;
      loop_out = '0;
      in_tag = '0;
      #1 rst_n = 1'b0;
      #1;
      check(in_ready, 0, "init_in_ready");
      check(loop_read, 0, "init_loop_read");
      check(out_valid, 0, "init_out_valid");
      check(busy, 1, "init_busy");
      check(protocol_err, 0, "init_protocol_err");
      reset_tail();
      // Drain with valid held and a spurious write at cycle 50, then a continuous burst.
      while (rel < 178) step(1'b1, 1'b1, rel == 49);
      check(protocol_err, 0, "drain_spurious_err");
      check(out_valid, 0, "drain_out_valid");
      check(busy, 1, "drain_busy");
      while (rel < 300) step(1'b1, 1'b1, 1'b0);
      check(n_acc, 19, "burst_accepts");
      while (rel < 420) step(1'b1, 1'b1, 1'b0);
      check(n_acc, 38, "slot_reuse_accepts");
      // Single item latency.
      do_reset();
      while (rel < 200) step(1'b0, 1'b1, 1'b0);
      next_tag = 8'h5A;
      step(1'b1, 1'b1, 1'b0);
      t0 = rel;
      check(n_acc, 1, "single_accept");
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         step(1'b0, 1'b0, 1'b0);
         seen = out_valid;
      end
      check(rel - t0, LAT + 1, "out_latency");
      check(out_tag, 8'h5A, "single_tag");
      step(1'b0, 1'b1, 1'b0);
      // Backpressure until credit is exhausted, then release.
      do_reset();
      while (rel < 560) step(1'b1, 1'b0, 1'b0);
      check(n_acc, ODEP, "credit_stop");
      check(out_valid, 1, "credit_out_valid");
      p0 = n_pop;
      repeat (32) step(1'b1, 1'b1, 1'b0);
      #2;
      check(n_pop - p0, 32, "drain_32");
      repeat (300) step($urandom_range(0, 3) != 0, 1'b1, 1'b0);
      check(n_acc > ODEP, 1, "issue_resumed");
      // Protocol error on an orphan write while idle.
      repeat (400) step(1'b0, 1'b1, 1'b0);
      check(busy, 0, "idle_busy");
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check(protocol_err, 1, "orphan_err");
      check(out_valid, 0, "orphan_dropped");
      check(busy, 0, "orphan_busy");
      repeat (600) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 1'b0);
      check(protocol_err, 1, "err_sticky");
      // Reset with items in flight; stale loop results must be ignored.
      do_reset();
      while (rel < 179) step(1'b0, 1'b1, 1'b0);
      repeat (10) step(1'b1, 1'b1, 1'b0);
      check(n_acc, 10, "inflight_accepts");
      do_reset();
      while (rel < 185) step(1'b1, 1'b1, 1'b0);
      repeat (400) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, 1'b0);
      check(protocol_err, 0, "stale_write_ignored");
      repeat (250) step(1'b0, 1'b1, 1'b0);
      #2;
      check(sb.size(), 0, "all_results_out");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
